rtc_cfg_seq: RTL

- APB4 master sequencer that programs and services the APB4 RTC peripheral. Target register map is fixed: CTRL 0x00, PSCR 0x04, CNT 0x08, ALRM 0x0C, ISTA 0x10, SSTA 0x14.
- On start, it unlocks the RTC and waits for the write-ready status. It then writes prescaler, counter and alarm, and finally writes the enable bits and locks the RTC.
- In run mode it acknowledges interrupts by reading ISTA, which clears it, and serves counter-read requests.
- Sits between the SoC housekeeping logic and the RTC's APB4 slave port.

---
 rtl/rtc_cfg_seq_pkg.sv | 40 ++++
 rtl/rtc_cfg_seq_apb4_mst_xfer.sv | 66 ++++++
 rtl/rtc_cfg_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_cfg_seq_pkg.sv
// Shared constants for the RTC configuration sequencer: RTC register map,
// CTRL/SSTA bit positions and the sequencer state encoding.
package rtc_cfg_pkg;

    localparam logic [7:0] RTC_CTRL_ADDR = 8'h00;
    localparam logic [7:0] RTC_PSCR_ADDR = 8'h04;
    localparam logic [7:0] RTC_CNT_ADDR  = 8'h08;
    localparam logic [7:0] RTC_ALRM_ADDR = 8'h0C;
    localparam logic [7:0] RTC_ISTA_ADDR = 8'h10;
    localparam logic [7:0] RTC_SSTA_ADDR = 8'h14;

    localparam int CTRL_WR_EN = 0;
    localparam int CTRL_TICK  = 1;
    localparam int CTRL_ALRM  = 2;
    localparam int CTRL_OV    = 3;
    localparam int CTRL_NORM  = 4;
    localparam int SSTA_WRDY  = 1;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_UNLOCK = 4'd1;
    localparam logic [3:0] ST_POLL   = 4'd2;
    localparam logic [3:0] ST_WPSCR  = 4'd3;
    localparam logic [3:0] ST_WCNT   = 4'd4;
    localparam logic [3:0] ST_WALRM  = 4'd5;
    localparam logic [3:0] ST_WCTRL  = 4'd6;
    localparam logic [3:0] ST_RUN    = 4'd7;
    localparam logic [3:0] ST_ISR    = 4'd8;
    localparam logic [3:0] ST_RDCNT  = 4'd9;
    localparam logic [3:0] ST_ERR    = 4'd10;

    // States that own exactly one APB transfer
    function automatic logic is_xfer_state(input logic [3:0] s);
        case (s)
            ST_UNLOCK, ST_POLL, ST_WPSCR, ST_WCNT,
            ST_WALRM, ST_WCTRL, ST_ISR, ST_RDCNT: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rtc_cfg_seq_apb4_mst_xfer.sv
// Single-transfer APB4 master: accepts one request while idle, runs SETUP then
// ACCESS until pready, and reports completion combinationally on that cycle.
module apb4_mst_xfer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              w_done;

    assign w_done    = r_psel & r_penable & i_pready;
    assign o_done    = w_done;
    assign o_err     = w_done & i_pslverr;
    assign o_rdata   = i_prdata;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;

    // APB phase sequencing; address/data held from SETUP through completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= {ADDR_W{1'b0}};
            r_pwdata  <= {DATA_W{1'b0}};
        end else if (!r_psel) begin
            if (i_req) begin
                r_psel   <= 1'b1;
                r_paddr  <= i_addr;
                r_pwrite <= i_wr;
                r_pwdata <= i_wdata;
            end
        end else if (!r_penable) begin
            r_penable <= 1'b1;
        end else if (i_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_cfg_seq.sv
// RTC configuration sequencer: unlocks and programs the RTC over APB4, then
// services interrupts (ISTA read-to-clear) and counter read requests.
module rtc_cfg_seq #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int POLL_MAX = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pscr_i,
    input  logic [DATA_W-1:0] cnt_i,
    input  logic [DATA_W-1:0] alrm_i,
    input  logic [3:0]        en_i,
    input  logic              irq_i,
    input  logic              rd_req_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        ista_o,
    output logic              ista_vld_o,
    output logic [DATA_W-1:0] cnt_o,
    output logic              cnt_vld_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);
    import rtc_cfg_pkg::*;

    localparam int            PW       = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

    logic [3:0]        r_state, w_next;
    logic              r_issued;
    logic [PW-1:0]     r_poll, w_poll_inc;
    logic [DATA_W-1:0] r_pscr, r_cnt, r_alrm;
    logic [3:0]        r_en;
    logic              r_rd_pend;
    logic [1:0]        r_irq_hold;
    logic              r_busy, r_done, r_err, r_ista_vld, r_cnt_vld;
    logic [2:0]        r_ista;
    logic [DATA_W-1:0] r_cnt_rd;

    logic              w_req, w_wr, w_xdone, w_xerr, w_irq_ok, w_rd_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata, w_rdata, w_ctrl_word;

    assign w_poll_inc = r_poll + PW'(1);
    // The first 2 cycles after an ISTA read see a stale irq level
    assign w_irq_ok   = irq_i && (r_irq_hold == 2'd0);
    assign w_rd_any   = rd_req_i || r_rd_pend;

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign ista_o     = r_ista;
    assign ista_vld_o = r_ista_vld;
    assign cnt_o      = r_cnt_rd;
    assign cnt_vld_o  = r_cnt_vld;

    apb4_mst_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_xfer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     (w_req),
        .i_addr    (w_addr),
        .i_wr      (w_wr),
        .i_wdata   (w_wdata),
        .o_done    (w_xdone),
        .o_rdata   (w_rdata),
        .o_err     (w_xerr),
        .o_paddr   (paddr_o),
        .o_psel    (psel_o),
        .o_penable (penable_o),
        .o_pwrite  (pwrite_o),
        .o_pwdata  (pwdata_o),
        .i_prdata  (prdata_i),
        .i_pready  (pready_i),
        .i_pslverr (pslverr_i)
    );

    // Final CTRL word: enables on, write-enable (lock) bit cleared
    always_comb begin
        w_ctrl_word            = {DATA_W{1'b0}};
        w_ctrl_word[CTRL_TICK] = r_en[0];
        w_ctrl_word[CTRL_ALRM] = r_en[1];
        w_ctrl_word[CTRL_OV]   = r_en[2];
        w_ctrl_word[CTRL_NORM] = r_en[3];
    end

    // Per-state APB request decode; one request is issued per state visit
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = ADDR_W'(RTC_CTRL_ADDR);
        w_wdata = {DATA_W{1'b0}};
        case (r_state)
            ST_UNLOCK: begin w_wr = 1'b1; w_wdata = DATA_W'(1) << CTRL_WR_EN; end
            ST_POLL:   w_addr = ADDR_W'(RTC_SSTA_ADDR);
            ST_WPSCR:  begin w_wr = 1'b1; w_addr = ADDR_W'(RTC_PSCR_ADDR); w_wdata = r_pscr; end
            ST_WCNT:   begin w_wr = 1'b1; w_addr = ADDR_W'(RTC_CNT_ADDR);  w_wdata = r_cnt;  end
            ST_WALRM:  begin w_wr = 1'b1; w_addr = ADDR_W'(RTC_ALRM_ADDR); w_wdata = r_alrm; end
            ST_WCTRL:  begin w_wr = 1'b1; w_wdata = w_ctrl_word; end
            ST_ISR:    w_addr = ADDR_W'(RTC_ISTA_ADDR);
            ST_RDCNT:  w_addr = ADDR_W'(RTC_CNT_ADDR);
            default:   w_wr = 1'b0;
        endcase
        w_req = is_xfer_state(r_state) && !r_issued;
    end

    // Next-state logic; any slave error on a completing transfer ends in ERR
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start_i) w_next = ST_UNLOCK;
                else         w_next = r_state;
            end
            ST_UNLOCK, ST_WPSCR, ST_WCNT, ST_WALRM, ST_WCTRL, ST_ISR, ST_RDCNT: begin
                if (!w_xdone)                 w_next = r_state;
                else if (w_xerr)              w_next = ST_ERR;
                else if (r_state == ST_WCTRL) w_next = ST_RUN;
                else if (r_state == ST_ISR)   w_next = ST_RUN;
                else if (r_state == ST_RDCNT) w_next = ST_RUN;
                else                          w_next = r_state + 4'd1;
            end
            ST_POLL: begin
                if (!w_xdone)                   w_next = ST_POLL;
                else if (w_xerr)                w_next = ST_ERR;
                else if (w_rdata[SSTA_WRDY])    w_next = ST_WPSCR;
                else if (w_poll_inc == POLL_LIM) w_next = ST_ERR;
                else                            w_next = ST_POLL;
            end
            ST_RUN: begin
                if (start_i)       w_next = ST_UNLOCK;
                else if (w_irq_ok) w_next = ST_ISR;
                else if (w_rd_any) w_next = ST_RDCNT;
                else               w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, captured configuration, status outputs and pending-request tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_issued   <= 1'b0;
            r_poll     <= {PW{1'b0}};
            r_pscr     <= {DATA_W{1'b0}};
            r_cnt      <= {DATA_W{1'b0}};
            r_alrm     <= {DATA_W{1'b0}};
            r_en       <= 4'd0;
            r_rd_pend  <= 1'b0;
            r_irq_hold <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ista     <= 3'd0;
            r_ista_vld <= 1'b0;
            r_cnt_rd   <= {DATA_W{1'b0}};
            r_cnt_vld  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != ST_IDLE) && (w_next != ST_RUN);
            r_done     <= (r_state == ST_WCTRL) && (w_next == ST_RUN);
            r_ista_vld <= 1'b0;
            r_cnt_vld  <= 1'b0;

            if (w_xdone)    r_issued <= 1'b0;
            else if (w_req) r_issued <= 1'b1;

            if ((w_next == ST_UNLOCK) && (r_state != ST_UNLOCK)) begin
                r_pscr <= pscr_i;
                r_cnt  <= cnt_i;
                r_alrm <= alrm_i;
                r_en   <= en_i;
                r_poll <= {PW{1'b0}};
                r_err  <= 1'b0;
            end else if ((r_state == ST_POLL) && w_xdone) begin
                r_poll <= w_poll_inc;
            end

            if ((w_next == ST_ERR) && (r_state != ST_ERR)) r_err <= 1'b1;

            if ((r_state == ST_ISR) && w_xdone && !w_xerr) begin
                r_ista     <= w_rdata[2:0];
                r_ista_vld <= 1'b1;
                r_irq_hold <= 2'd2;
            end else if (r_irq_hold != 2'd0) begin
                r_irq_hold <= r_irq_hold - 2'd1;
            end

            if ((r_state == ST_RDCNT) && w_xdone && !w_xerr) begin
                r_cnt_rd  <= w_rdata;
                r_cnt_vld <= 1'b1;
            end

            if ((r_state == ST_RUN) && (w_next == ST_RDCNT)) r_rd_pend <= 1'b0;
            else if (rd_req_i)                               r_rd_pend <= 1'b1;
        end
    end

endmodule
